regfile_param: RTL and testbench
================================

# regfile_param

Parametrised 2-read/1-write register file with registered read ports, a hardware clear sequencer and an optional hardwired-zero entry. It is the next-generation register storage for the datapath: width and depth are configurable, and it replaces fixed 32x32 decoder-and-word arrays. Read ports load on the clock edge when enabled and otherwise hold their value. A single `CLR` pulse zeroes the whole array, one entry per cycle, while `BUSY` is asserted.

## Interface
- `WIDTH`, 32, data width in bits.
- `AW`, 5, address width; depth `DEPTH = 2**AW`.
- `ZERO_REG`, 1, when 1 entry 0 always reads 0 and ignores writes.
- `clk`  input  1  clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `WE`  input  1  write enable.
- `WA`  input  AW  write address.
- `IN`  input  WIDTH  write data.
- `RE_A`  input  1  read enable, port A.
- `RA_A`  input  AW  read address, port A.
- `RE_B`  input  1  read enable, port B.
- `RA_B`  input  AW  read address, port B.
- `CLR`  input  1  start-clear request, sampled when idle.
- `OutA`  output  WIDTH  registered read data, port A.
- `OutB`  output  WIDTH  registered read data, port B.
- `BUSY`  output  1  clear sequence in progress.

## Operation
- **Reset** (`rst`=1, asynchronous): all entries 0, `OutA`=`OutB`=0, `BUSY`=0, state IDLE, clear counter 0.
- **Write:** on an edge with `WE`=1 and `BUSY`=0, the block sets mem[`WA`] to `IN`.
  - The write is dropped when `BUSY`=1.
  - The write is dropped when `ZERO_REG`=1 and `WA`=0.
- **Read:** on an edge with `RE_x`=1, the block sets `Out_x` to mem[`RA_x`].
  - `RE_x`=0 leaves `Out_x` unchanged.
  - Reads proceed normally during `BUSY`.
  - Entry 0 returns 0 when `ZERO_REG`=1.
- **Same-address read and write:** mem receives the new value. `Out_x` receives the pre-write value (see Configuration).
- **State machine:**
  - IDLE → CLEARING on an edge with `CLR`=1. Counter is set to 0.
  - In CLEARING, each edge zeroes mem[counter] and increments the counter.
  - After the edge that zeroes entry `DEPTH-1`, the block returns to IDLE and the counter wraps to 0.
  - `CLR` is ignored in CLEARING; there is no restart.
- **Simultaneous `WE` and `CLR` in IDLE:** the write is performed on that edge. The sequence then clears that entry in turn.
- **Reset mid-clear:** the block goes immediately to IDLE with the full array zeroed.

## Timing
- Read latency is 1 cycle: address at edge N, data valid after edge N.
- Write is visible to reads sampled on edge N+1 or later.
- `BUSY` rises after the edge that samples `CLR`. It is high for exactly `DEPTH` cycles and falls after the last clearing edge.
- Entry k is zeroed on the (k+1)-th edge after `CLR` is sampled.
- `BUSY` is a registered output, with no combinational path from `CLR`.
- `OutA`/`OutB` are registered outputs, with no combinational path from inputs.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- **Defined:** write-to-read forwarding.
  - If a write is accepted on an edge where `RE_x`=1 and `RA_x`=`WA`, then `Out_x` loads `IN`.
  - If a clearing edge zeroes the entry read by an enabled port, then `Out_x` loads 0.
  - No forwarding applies to entry 0 when `ZERO_REG`=1.
- **Undefined:** no forwarding. `Out_x` loads the pre-edge stored value.

## Test plan
- **Reset then read:** reset, then read all 32 addresses on both ports → every read returns 0 and `BUSY`=0.
- **Write then read, dual port:** write 0xDEADBEEF to 5 and 0x12345678 to 9. Then `RA_A`=5, `RA_B`=9 with both enables → after 1 edge, `OutA`=0xDEADBEEF and `OutB`=0x12345678. Deassert enables and change addresses → outputs hold.
- **Zero register:** with `ZERO_REG`=1, write 0xFFFFFFFF to 0 → read 0 returns 0.
- **Same-address read and write:** write 0xA5A5A5A5 to 7 while reading 7, where mem[7]=0x11 → `OutA`=0xA5A5A5A5 with `REGFILE_BYPASS_EN` defined, 0x11 without. The next read returns 0xA5A5A5A5 in both builds.
- **Clear sequence:**
  - Fill all entries, then pulse `CLR` → `BUSY` high for exactly 32 cycles.
  - A `WE` to 3 during `BUSY` is ignored.
  - A second `CLR` during `BUSY` is ignored.
  - Afterwards all entries read 0.
- **Reset mid-clear:** assert `rst` for 1 cycle at cycle 10 of `CLR` → `BUSY`=0 immediately, all entries 0, and a new `CLR` is accepted afterwards.

Source files
------------

// File: rtl/regfile_param.sv
// regfile_param: parametrised 2-read/1-write register file.
// - Read ports are registered and hold their value when not enabled.
// - A one-entry-per-cycle clear sequencer zeroes the whole array while BUSY is high.
// - When ZERO_REG=1, entry 0 is hardwired to zero.
// Optional feature (macro REGFILE_BYPASS_EN): write-to-read forwarding, so a
// read of an entry being written or cleared on the same edge returns the new value.
module regfile_param #(
  parameter int WIDTH    = 32,
  parameter int AW       = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             WE,
  input  logic [AW-1:0]    WA,
  input  logic [WIDTH-1:0] IN,
  input  logic             RE_A,
  input  logic [AW-1:0]    RA_A,
  input  logic             RE_B,
  input  logic [AW-1:0]    RA_B,
  input  logic             CLR,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB,
  output logic             BUSY
);

  localparam int DEPTH = 2**AW;

  typedef enum logic {IDLE = 1'b0, CLEARING = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] out_a_q, out_a_d;
  logic [WIDTH-1:0] out_b_q, out_b_d;
  logic             wr_ok;
  logic             clr_act;

  // Writes are accepted only while idle; entry 0 is protected when hardwired.
  assign clr_act = (state_q == CLEARING);
  assign wr_ok   = WE && !clr_act && !(ZERO_REG && (WA == '0));

  // Clear sequencer: walk the counter across every entry once, then go idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (CLR) begin
          state_d = CLEARING;
          cnt_d   = '0;
        end
      end
      CLEARING: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // Next array contents: accepted write or the entry being cleared (never both).
  always_comb begin
    mem_d = mem_q;
    if (wr_ok) begin
      mem_d[WA] = IN;
    end
    if (clr_act) begin
      mem_d[cnt_q] = '0;
    end
  end

  // Read port A: load on enable, otherwise hold.
  always_comb begin
    out_a_d = out_a_q;
    if (RE_A) begin
      out_a_d = mem_q[RA_A];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (WA == RA_A)) begin
        out_a_d = IN;
      end
      if (clr_act && (cnt_q == RA_A)) begin
        out_a_d = '0;
      end
`endif
      if (ZERO_REG && (RA_A == '0)) begin
        out_a_d = '0;
      end
    end
  end

  // Read port B: load on enable, otherwise hold.
  always_comb begin
    out_b_d = out_b_q;
    if (RE_B) begin
      out_b_d = mem_q[RA_B];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (WA == RA_B)) begin
        out_b_d = IN;
      end
      if (clr_act && (cnt_q == RA_B)) begin
        out_b_d = '0;
      end
`endif
      if (ZERO_REG && (RA_B == '0)) begin
        out_b_d = '0;
      end
    end
  end

  // State, counter, array and read registers; reset zeroes everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_a_q <= '0;
      out_b_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_a_q <= out_a_d;
      out_b_q <= out_b_d;
      mem_q   <= mem_d;
    end
  end

  assign OutA = out_a_q;
  assign OutB = out_b_q;
  assign BUSY = clr_act;

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param (default parameters, ZERO_REG=1).
// Expectations follow REGFILE_BYPASS_EN the same way the design build does.
module tb_regfile_param;

  localparam int  WIDTH = 32;
  localparam int  AW    = 5;
  localparam int  DEPTH = 32;
  localparam bit  ZR    = 1'b1;

  logic             clk = 1'b0;
  logic             rst;
  logic             WE;
  logic [AW-1:0]    WA;
  logic [WIDTH-1:0] IN;
  logic             RE_A;
  logic [AW-1:0]    RA_A;
  logic             RE_B;
  logic [AW-1:0]    RA_B;
  logic             CLR;
  logic [WIDTH-1:0] OutA;
  logic [WIDTH-1:0] OutB;
  logic             BUSY;

  regfile_param #(.WIDTH(WIDTH), .AW(AW), .ZERO_REG(ZR)) dut (
    .clk(clk), .rst(rst), .WE(WE), .WA(WA), .IN(IN),
    .RE_A(RE_A), .RA_A(RA_A), .RE_B(RE_B), .RA_B(RA_B),
    .CLR(CLR), .OutA(OutA), .OutB(OutB), .BUSY(BUSY)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [WIDTH-1:0] m [DEPTH];
  logic [WIDTH-1:0] exp_a, exp_b;
  bit               m_busy;
  int               m_idx;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [WIDTH-1:0] got,
                           input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [WIDTH-1:0] model_read(input int ra, input bit wok);
    if (ZR && ra == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wok && ra == int'(WA)) return IN;
    if (m_busy && ra == m_idx) return '0;
`endif
    return m[ra];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m[i] = '0;
    exp_a  = '0;
    exp_b  = '0;
    m_busy = 1'b0;
    m_idx  = 0;
  endtask

  // One clock: advance the model on the current inputs, then check the DUT.
  task automatic cycle();
    bit wok;
    wok = WE && !m_busy && !(ZR && WA == '0);
    if (RE_A) exp_a = model_read(int'(RA_A), wok);
    if (RE_B) exp_b = model_read(int'(RA_B), wok);
    if (wok) m[WA] = IN;
    if (m_busy) begin
      m[m_idx] = '0;
      m_idx++;
      if (m_idx == DEPTH) begin
        m_busy = 1'b0;
        m_idx  = 0;
      end
    end else if (CLR) begin
      m_busy = 1'b1;
      m_idx  = 0;
    end
    @(posedge clk);
    #1;
    check_val("busy", {31'b0, BUSY}, {31'b0, m_busy});
    check_val("out_a", OutA, exp_a);
    check_val("out_b", OutB, exp_b);
  endtask

  task automatic idle_inputs();
    WE = 1'b0; WA = '0; IN = '0;
    RE_A = 1'b0; RA_A = '0; RE_B = 1'b0; RA_B = '0; CLR = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_val("rst_busy", {31'b0, BUSY}, 32'd0);
    check_val("rst_out_a", OutA, 32'd0);
    check_val("rst_out_b", OutB, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic write(input int a, input logic [WIDTH-1:0] d);
    WE = 1'b1; WA = AW'(a); IN = d;
    cycle();
    WE = 1'b0;
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) begin
      RE_A = 1'b1; RA_A = AW'(i);
      RE_B = 1'b1; RA_B = AW'(DEPTH - 1 - i);
      cycle();
      check_val("all_a", OutA, model_read(i, 1'b0));
    end
    RE_A = 1'b0; RE_B = 1'b0;
  endtask

  task automatic fill_all();
    for (int i = 0; i < DEPTH; i++) write(i, $urandom | 32'h1);
  endtask

  int busy_len;
  int guard;

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    #2;
    do_reset();

    // Reset then read everything on both ports
    read_all();

    // Dual-port write/read and hold
    write(5, 32'hDEADBEEF);
    write(9, 32'h12345678);
    RE_A = 1'b1; RA_A = 5'd5; RE_B = 1'b1; RA_B = 5'd9;
    cycle();
    check_val("dp_a", OutA, 32'hDEADBEEF);
    check_val("dp_b", OutB, 32'h12345678);
    RE_A = 1'b0; RA_A = 5'd1; RE_B = 1'b0; RA_B = 5'd2;
    cycle();
    cycle();
    check_val("hold_a", OutA, 32'hDEADBEEF);
    check_val("hold_b", OutB, 32'h12345678);

    // Hardwired zero entry
    write(0, 32'hFFFFFFFF);
    RE_A = 1'b1; RA_A = 5'd0; RE_B = 1'b1; RA_B = 5'd0;
    cycle();
    check_val("zero_a", OutA, 32'd0);
    check_val("zero_b", OutB, 32'd0);
    RE_A = 1'b0; RE_B = 1'b0;

    // Same-address read and write
    write(7, 32'h11);
    WE = 1'b1; WA = 5'd7; IN = 32'hA5A5A5A5; RE_A = 1'b1; RA_A = 5'd7;
    cycle();
`ifdef REGFILE_BYPASS_EN
    check_val("raw_a", OutA, 32'hA5A5A5A5);
`else
    check_val("raw_a", OutA, 32'h11);
`endif
    WE = 1'b0;
    cycle();
    check_val("raw_next", OutA, 32'hA5A5A5A5);
    RE_A = 1'b0;

    // Clear sequence with ignored write and ignored second CLR
    fill_all();
    CLR = 1'b1;
    cycle();
    CLR = 1'b0;
    busy_len = 0;
    guard = 0;
    while (BUSY && guard < 100) begin
      busy_len++;
      guard++;
      WE = (busy_len == 4); WA = 5'd3; IN = 32'hCAFEF00D;
      CLR = (busy_len == 6);
      RE_A = 1'b1; RA_A = AW'($urandom_range(0, DEPTH - 1));
      RE_B = 1'b1; RA_B = AW'(busy_len - 1);
      cycle();
    end
    idle_inputs();
    check_val("busy_len", busy_len, 32'd32);
    read_all();
    RE_A = 1'b1; RA_A = 5'd3;
    cycle();
    check_val("clr_we3", OutA, 32'd0);
    RE_A = 1'b0;

    // Reset mid-clear, then a fresh clear is accepted
    fill_all();
    CLR = 1'b1;
    cycle();
    CLR = 1'b0;
    for (int i = 0; i < 9; i++) cycle();
    do_reset();
    read_all();
    fill_all();
    CLR = 1'b1;
    cycle();
    CLR = 1'b0;
    check_val("reclr_busy", {31'b0, BUSY}, 32'd1);
    guard = 0;
    while (BUSY && guard < 100) begin
      guard++;
      cycle();
    end
    check_val("reclr_done", {31'b0, BUSY}, 32'd0);
    read_all();

    // Randomised traffic against the model
    for (int n = 0; n < 1500; n++) begin
      WE   = $urandom_range(0, 1);
      WA   = AW'($urandom_range(0, DEPTH - 1));
      IN   = $urandom;
      RE_A = $urandom_range(0, 3) != 0;
      RA_A = ($urandom_range(0, 2) == 0) ? WA : AW'($urandom_range(0, DEPTH - 1));
      RE_B = $urandom_range(0, 3) != 0;
      RA_B = AW'($urandom_range(0, DEPTH - 1));
      CLR  = ($urandom_range(0, 63) == 0);
      cycle();
    end
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
